// File: rtl/uart_tx_cfg_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg_pkg
//   Shared types for the configurable UART transmitter.
//   Parity_t     : NONE / EVEN / ODD parity selection (encoding 3 maps to NONE)
//   TxState_t    : transmitter FSM states
//   TXIrqFlags_t : registered interrupt pulses (frame done, FIFO drained)
// -----------------------------------------------------------------------------
package uart_tx_cfg_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } Parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } TxState_t;

  typedef struct packed {
    logic done;
    logic empty;
  } TXIrqFlags_t;

  localparam logic [3:0] MIN_BITS     = 4'd5;
  localparam logic [3:0] DEFAULT_BITS = 4'd8;

  // The unused encoding 3 behaves as "no parity".
  function automatic Parity_t to_parity(input logic [1:0] p);
    case (p)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_cfg_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg_fifo
//   Circular-buffer storage for the TX FIFO. Occupancy is tracked by the
//   parent, which only issues push/pop when legal; a push and a pop in the
//   same cycle both take effect. The head word is presented combinationally.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : return both pointers to 0 (FIFO becomes empty)
//   push_i     : write wdata_i at the tail
//   pop_i      : advance the head
//   wdata_i    : word to store
//   rdata_o    : word at the head
// -----------------------------------------------------------------------------
module uart_tx_cfg_fifo #(
  parameter int data_size   = 9,
  parameter int buffer_size = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [data_size-1:0] wdata_i,
  output logic [data_size-1:0] rdata_o
);

  localparam int PTR_W = $clog2(buffer_size);

  logic [data_size-1:0] mem_q [buffer_size];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; stale words are unreachable because the
  // pointers (which are reset) define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
//   FIFO-buffered UART transmitter: 5..DATA_W_MAX data bits, none/even/odd
//   parity, 1 or 2 stop bits, optional RTS/CTS flow control, break generation.
//   Bit timing is driven by the one-cycle baud_tick enable.
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   baud_tick                  : one pulse per bit period
//   wdata, wvalid, wready      : enqueue port (wready = !full && !flush)
//   tx                         : serial line, idle high
//   tx_rts_n, tx_cts_n         : flow control (active low)
//   cfg_data_bits/parity/stop2 : frame format, latched at frame start
//   cfg_flow_en                : honour CTS, drive RTS
//   cfg_flush, cfg_break       : level controls
//   fifo_full/empty/level      : FIFO status
//   busy                       : FSM not idle
//   irq_done, irq_empty        : one-cycle event pulses
// -----------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int DATA_W_MAX = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic [DATA_W_MAX-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic                  tx,
  output logic                  tx_rts_n,
  input  logic                  tx_cts_n,
  input  logic [3:0]            cfg_data_bits,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic                  cfg_flow_en,
  input  logic                  cfg_flush,
  input  logic                  cfg_break,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  busy,
  output logic                  irq_done,
  output logic                  irq_empty
);

  import uart_tx_cfg_pkg::*;

  localparam logic [3:0]       MAX_BITS = 4'(DATA_W_MAX);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  TxState_t              state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  rts_n_q, rts_n_d;
  logic [DATA_W_MAX-1:0] shift_q, shift_d;
  logic [DATA_W_MAX-1:0] frame_q, frame_d;   // unshifted copy for parity
  logic [3:0]            bits_q, bits_d;
  logic [3:0]            cnt_q, cnt_d;       // data bit / stop bit / break-tail counter
  Parity_t               par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  rel_q, rel_d;       // break released, sending the idle tail
  TXIrqFlags_t           irq_q, irq_d;
  logic [LVL_W-1:0]      level_q, level_d;

  logic                  push, pop, frame_done, par_even;
  logic [DATA_W_MAX-1:0] fifo_rdata, data_mask;
  logic [3:0]            bits_eff;

  // ---------------------------------------------------------------- FIFO ----
  assign fifo_full  = (level_q == LVL_FULL);
  assign fifo_empty = (level_q == '0);
  assign wready     = !fifo_full && !cfg_flush;
  assign push       = wvalid && wready;

  uart_tx_cfg_fifo #(
    .data_size  (DATA_W_MAX),
    .buffer_size(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(cfg_flush),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(wdata),
    .rdata_o(fifo_rdata)
  );

  always_comb begin
    level_d = level_q;
    if (cfg_flush) begin
      level_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // ------------------------------------------------------------- datapath ---
  assign bits_eff  = (cfg_data_bits >= MIN_BITS && cfg_data_bits <= MAX_BITS)
                     ? cfg_data_bits : DEFAULT_BITS;
  assign data_mask = ~({DATA_W_MAX{1'b1}} << bits_q);
  assign par_even  = ^(frame_q & data_mask);
  assign busy      = (state_q != ST_IDLE);

  // ------------------------------------------------------------------ FSM ---
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned (which would infer a latch).
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    frame_d    = frame_q;
    bits_d     = bits_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    cnt_d      = cnt_q;
    rel_d      = rel_q;
    pop        = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_break) begin
          // Break entry does not wait for a tick.
          state_d = ST_BREAK;
          tx_d    = 1'b0;
          rel_d   = 1'b0;
          cnt_d   = '0;
        end else if (baud_tick && !fifo_empty && !cfg_flush &&
                     (!cfg_flow_en || !tx_cts_n)) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          frame_d = fifo_rdata;
          bits_d  = bits_eff;
          par_d   = to_parity(cfg_parity);
          stop2_d = cfg_stop2;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = 4'd1;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (cnt_q == bits_q) begin
            cnt_d = '0;
            if (par_q != PAR_NONE) begin
              tx_d    = (par_q == PAR_ODD) ? ~par_even : par_even;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 4'd1;
          end
        end
      end

      ST_PARITY: begin
        if (baud_tick) begin
          tx_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (baud_tick) begin
          if (stop2_q && cnt_q == '0) begin
            cnt_d = 4'd1;
          end else begin
            cnt_d      = '0;
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      ST_BREAK: begin
        if (baud_tick) begin
          if (!rel_q) begin
            if (!cfg_break) begin
              tx_d  = 1'b1;
              rel_d = 1'b1;
              cnt_d = '0;
            end
          end else if (cnt_q == 4'd1) begin
            cnt_d   = '0;
            rel_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    irq_d.done  = frame_done;
    irq_d.empty = pop && !push && (level_q == LVL_ONE) && !cfg_flush;
    rts_n_d     = !(cfg_flow_en && (!fifo_empty || busy));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      rts_n_q <= 1'b1;
      shift_q <= '0;
      frame_q <= '0;
      bits_q  <= DEFAULT_BITS;
      cnt_q   <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      rel_q   <= 1'b0;
      irq_q   <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rts_n_q <= rts_n_d;
      shift_q <= shift_d;
      frame_q <= frame_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      rel_q   <= rel_d;
      irq_q   <= irq_d;
      level_q <= level_d;
    end
  end

  assign tx         = tx_q;
  assign tx_rts_n   = rts_n_q;
  assign irq_done   = irq_q.done;
  assign irq_empty  = irq_q.empty;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
//   Scoreboard bench for uart_tx_cfg. Each accepted write pushes the expected
//   line waveform (start, data LSB first, parity, stops) into a queue; a
//   monitor samples tx once per bit period, pops the expectation when it sees
//   a start bit and compares the whole frame plus the irq_done pulse.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int DW    = 9;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk, rst_n, baud_tick;
  logic [DW-1:0] wdata;
  logic          wvalid, wready, tx, tx_rts_n, tx_cts_n;
  logic [3:0]    cfg_data_bits;
  logic [1:0]    cfg_parity;
  logic          cfg_stop2, cfg_flow_en, cfg_flush, cfg_break;
  logic          fifo_full, fifo_empty, busy, irq_done, irq_empty;
  logic [LW-1:0] fifo_level;

  uart_tx_cfg #(.DATA_W_MAX(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .tx(tx), .tx_rts_n(tx_rts_n), .tx_cts_n(tx_cts_n),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .cfg_flow_en(cfg_flow_en),
    .cfg_flush(cfg_flush), .cfg_break(cfg_break),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .busy(busy), .irq_done(irq_done), .irq_empty(irq_empty)
  );

  typedef struct {
    logic [15:0] seq;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          cap_active, done_wait, mon_en;
  logic [15:0] cap_seq;
  int          cap_idx;
  int          n_checks, n_err, ie_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tick every 4 clocks.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Expected line sequence for one word, straight from the frame format rules.
  function automatic exp_t build_frame(input logic [DW-1:0] d, input int nb_cfg,
                                       input int par, input bit s2);
    exp_t e;
    int   nb, n;
    bit   p;
    nb    = (nb_cfg >= 5 && nb_cfg <= DW) ? nb_cfg : 8;
    e.seq = '0;
    n     = 1;              // bit 0 is the start bit (0)
    p     = 1'b0;
    for (int i = 0; i < nb; i++) begin
      e.seq[n] = d[i];
      p        = p ^ d[i];
      n        = n + 1;
    end
    if (par == 1) begin e.seq[n] = p;  n = n + 1; end
    if (par == 2) begin e.seq[n] = !p; n = n + 1; end
    e.seq[n] = 1'b1; n = n + 1;
    if (s2) begin e.seq[n] = 1'b1; n = n + 1; end
    e.len = n;
    return e;
  endfunction

  // Monitor: one sample of tx per bit period, just after the tick edge.
  initial begin : monitor
    logic t;
    cap_active = 1'b0;
    done_wait  = 1'b0;
    forever begin
      @(posedge clk);
      t = baud_tick;
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        cap_active = 1'b0;
        done_wait  = 1'b0;
      end else if (t) begin
        if (done_wait) begin
          check("irq_done_pulse", irq_done, 1);
          done_wait = 1'b0;
        end else begin
          check("irq_done_quiet", irq_done, 0);
          if (cap_active) begin
            cap_seq[cap_idx] = tx;
            cap_idx++;
            if (cap_idx == cur.len) begin
              cap_active = 1'b0;
              check("frame_bits", cap_seq, cur.seq);
              done_wait = 1'b1;
            end
          end else if (tx == 1'b0) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_err++;
              $display("FAIL unexpected_frame: start bit seen, expected none queued");
            end else begin
              cur        = exp_q.pop_front();
              cap_seq    = '0;
              cap_idx    = 1;
              cap_active = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : irq_empty_counter
    ie_cnt = 0;
    forever begin
      @(negedge clk);
      if (irq_empty === 1'b1) ie_cnt++;
    end
  end

  task automatic write_word(input logic [DW-1:0] d);
    @(negedge clk);
    if (exp_q.size() < DEPTH && !cfg_flush)
      exp_q.push_back(build_frame(d, int'(cfg_data_bits), int'(cfg_parity), cfg_stop2));
    wdata  = d;
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic wait_tick();
    logic t;
    t = 1'b0;
    while (!t) begin
      @(posedge clk);
      t = baud_tick;
      @(negedge clk);
    end
  endtask

  task automatic wait_cap(input string name);
    int c = 0;
    while (!cap_active && c < 400) begin @(negedge clk); c++; end
    check({name, "_start_timeout"}, c >= 400, 0);
  endtask

  task automatic wait_frame_end(input string name);
    int c = 0;
    while ((cap_active || done_wait) && c < 400) begin @(negedge clk); c++; end
    check({name, "_end_timeout"}, c >= 400, 0);
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || cap_active || done_wait || busy) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({name, "_drain_timeout"}, c >= 3000, 0);
  endtask

  task automatic set_cfg(input int nb, input int par, input bit s2);
    @(negedge clk);
    cfg_data_bits = 4'(nb);
    cfg_parity    = 2'(par);
    cfg_stop2     = s2;
  endtask

  task automatic run_one(input string name, input int nb, input int par,
                         input bit s2, input logic [DW-1:0] d);
    int ie0;
    set_cfg(nb, par, s2);
    ie0 = ie_cnt;
    write_word(d);
    drain(name);
    check({name, "_irq_empty"}, ie_cnt - ie0, 1);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int ie0, nw, r;
    n_checks = 0; n_err = 0; mon_en = 1'b1;
    rst_n = 1'b0; wdata = '0; wvalid = 1'b0; tx_cts_n = 1'b0;
    cfg_data_bits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    cfg_flow_en = 1'b0; cfg_flush = 1'b0; cfg_break = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_rts_n", tx_rts_n, 1);
    check("rst_busy", busy, 0);
    check("rst_irq", {irq_done, irq_empty}, 0);
    check("rst_empty_full", {fifo_empty, fifo_full}, 2'b10);
    check("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_wready", wready, 1);

    // Directed formats.
    run_one("f8n1_55",  8, 0, 1'b0, 9'h055);
    run_one("f7e2_41",  7, 1, 1'b1, 9'h041);
    run_one("f8o1_ff",  8, 2, 1'b0, 9'h0FF);
    run_one("f9n1_1aa", 9, 0, 1'b0, 9'h1AA);
    run_one("f9o2_0c3", 9, 2, 1'b1, 9'h0C3);
    run_one("clamp_3",  3, 3, 1'b0, 9'h1E7);

    // Config change during a frame only applies to the next frame.
    set_cfg(8, 0, 1'b0);
    write_word(9'h03C);
    wait_cap("cfgchg");
    set_cfg(5, 2, 1'b1);
    drain("cfgchg_old");
    run_one("cfgchg_new", 5, 2, 1'b1, 9'h013);

    // Flow control: CTS blocks, RTS asserted, CTS mid-frame does not abort.
    set_cfg(8, 0, 1'b0);
    cfg_flow_en = 1'b1;
    tx_cts_n    = 1'b1;
    repeat (3) write_word(9'($urandom_range(0, 511)));
    repeat (3) @(negedge clk);
    check("flow_rts_low", tx_rts_n, 0);
    repeat (8) wait_tick();
    check("flow_blocked_busy", busy, 0);
    check("flow_blocked_tx", tx, 1);
    check("flow_blocked_level", fifo_level, 3);
    ie0 = ie_cnt;
    tx_cts_n = 1'b0;
    wait_cap("flow1");
    @(negedge clk);
    tx_cts_n = 1'b1;
    wait_frame_end("flow1");
    repeat (4) wait_tick();
    check("flow_cts_hold_level", fifo_level, 2);
    check("flow_cts_hold_busy", busy, 0);
    @(negedge clk);
    tx_cts_n = 1'b0;
    drain("flow_rest");
    check("flow_irq_empty", ie_cnt - ie0, 1);
    repeat (3) @(negedge clk);
    check("flow_rts_idle", tx_rts_n, 1);

    // Full FIFO, dropped write, flush while a frame is in flight.
    tx_cts_n = 1'b1;
    repeat (DEPTH) write_word(9'($urandom_range(0, 511)));
    check("full_flag", fifo_full, 1);
    check("full_wready", wready, 0);
    check("full_level", fifo_level, DEPTH);
    write_word(9'h1FF);
    check("full_drop_level", fifo_level, DEPTH);
    tx_cts_n = 1'b0;
    wait_cap("flush");
    repeat (2) wait_tick();
    @(posedge clk);
    #2 cfg_flush = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("flush_level", fifo_level, 0);
    check("flush_empty", fifo_empty, 1);
    check("flush_wready", wready, 0);
    check("flush_busy", busy, 1);
    write_word(9'h0AA);
    check("flush_write_drop", fifo_level, 0);
    @(negedge clk);
    cfg_flush = 1'b0;
    drain("flush_inflight");
    check("flush_after_level", fifo_level, 0);
    cfg_flow_en = 1'b0;

    // Randomised formats against the frame model.
    for (int it = 0; it < 8; it++) begin
      r = int'($urandom_range(0, 9));
      set_cfg((r < 8) ? 5 + (r % 5) : int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      nw = int'($urandom_range(1, 4));
      for (int k = 0; k < nw; k++) write_word(9'($urandom_range(0, 511)));
      drain("random");
    end

    // Break: low while requested, then two high ticks before idle.
    wait_tick();
    @(posedge clk);
    #2 mon_en = 1'b0;
    cfg_break = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("brk_enter_busy", busy, 1);
    check("brk_enter_tx", tx, 0);
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      check("brk_low", tx, 0);
    end
    cfg_break = 1'b0;
    wait_tick();
    check("brk_rel1", {tx, busy}, 2'b11);
    wait_tick();
    check("brk_rel2", {tx, busy}, 2'b11);
    wait_tick();
    check("brk_idle", {tx, busy}, 2'b10);
    @(negedge clk);
    mon_en = 1'b1;

    // Reset in the middle of a frame.
    set_cfg(8, 1, 1'b0);
    write_word(9'h0A5);
    write_word(9'h05A);
    wait_cap("rst_mid");
    repeat (3) wait_tick();
    @(posedge clk);
    #2 mon_en = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rstmid_tx", tx, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_level", fifo_level, 0);
    check("rstmid_empty", fifo_empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    run_one("post_rst", 8, 0, 1'b0, 9'h0C1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
